// File: rtl/regfile_bus_sequencer_if.sv
// Command/bus interface for regfile_bus_sequencer.
//   Command side : cmd_valid/cmd_ready handshake carrying op, dst, src and imm.
//   Bus side     : bus_in is the sampled shared bus. reg_index, reg_rEn and
//                  reg_wEn strobe the register file. bus_load and bus_val
//                  control the bus driver.
//   Result side  : rsp_valid/rsp_data carry READ results. done pulses when a
//                  write completes.
// master = decode logic plus register file/bus driver; slave = sequencer.
interface regfile_bus_sequencer_if #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 4
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [IDX_W-1:0]  cmd_dst;
   logic [IDX_W-1:0]  cmd_src;
   logic [DATA_W-1:0] cmd_imm;
   logic [DATA_W-1:0] bus_in;
   logic [IDX_W-1:0]  reg_index;
   logic              reg_rEn;
   logic              reg_wEn;
   logic              bus_load;
   logic [DATA_W-1:0] bus_val;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              done;

   modport master (
      output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, bus_in,
      input  cmd_ready, reg_index, reg_rEn, reg_wEn, bus_load, bus_val,
             rsp_valid, rsp_data, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, bus_in,
      output cmd_ready, reg_index, reg_rEn, reg_wEn, bus_load, bus_val,
             rsp_valid, rsp_data, done
   );
endinterface

// File: rtl/regfile_bus_sequencer.sv
// regfile_bus_sequencer: expands one command at a time into register-file and
// bus-driver strobes. The register file and the bus driver never drive the
// shared bus in the same cycle.
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset
//   bus   : slave side of regfile_bus_sequencer_if (command, strobes, result)
// Every output except cmd_ready comes from a flop. Each flop is loaded with the
// Moore decode of the next state, so its value lines up with the state it
// describes.
module regfile_bus_sequencer #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 4
) (
   input logic                    clk,
   input logic                    reset,
   regfile_bus_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, RD, DRV, WR, RSP} state_t;
   typedef enum logic [1:0] {OP_LOADI, OP_MOVE, OP_READ, OP_CLEAR} op_t;

   state_t            state, state_nx;
   op_t               op, op_nx;
   logic [IDX_W-1:0]  dst, dst_nx, src, src_nx;
   logic [DATA_W-1:0] hold, hold_nx;

   logic [IDX_W-1:0]  index_nx;
   logic              ren_nx, wen_nx, load_nx, rsp_valid_nx, done_nx;
   logic [DATA_W-1:0] val_nx, rsp_data_nx;

   assign bus.cmd_ready = (state == IDLE) && reset;

   always_comb begin
      state_nx = state;
      op_nx    = op;
      dst_nx   = dst;
      src_nx   = src;
      hold_nx  = hold;
      unique case (state)
         IDLE: begin
            if (bus.cmd_valid && bus.cmd_ready) begin
               op_nx  = op_t'(bus.cmd_op);
               dst_nx = bus.cmd_dst;
               src_nx = bus.cmd_src;
               unique case (op_t'(bus.cmd_op))
                  OP_LOADI: begin hold_nx = bus.cmd_imm; state_nx = DRV; end
                  OP_CLEAR: begin hold_nx = '0;          state_nx = DRV; end
                  default:  state_nx = RD;
               endcase
            end
         end
         RD: begin
            // The register drives the bus during RD. Capture it at the closing edge.
            hold_nx  = bus.bus_in;
            state_nx = (op == OP_MOVE) ? DRV : RSP;
         end
         DRV:     state_nx = WR;
         WR:      state_nx = IDLE;
         RSP:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      // Output decode of the next state. reg_index, bus_val and rsp_data
      // keep their last values unless the next state defines them.
      index_nx     = bus.reg_index;
      val_nx       = bus.bus_val;
      rsp_data_nx  = bus.rsp_data;
      ren_nx       = 1'b0;
      wen_nx       = 1'b0;
      load_nx      = 1'b0;
      rsp_valid_nx = 1'b0;
      done_nx      = 1'b0;
      unique case (state_nx)
         RD: begin
            index_nx = src_nx;
            ren_nx   = 1'b1;
         end
         DRV: begin
            index_nx = dst_nx;
            load_nx  = 1'b1;
            val_nx   = hold_nx;
         end
         WR: begin
            index_nx = dst_nx;
            load_nx  = 1'b1;
            val_nx   = hold_nx;
            wen_nx   = 1'b1;
            done_nx  = 1'b1;
         end
         RSP: begin
            rsp_valid_nx = 1'b1;
            rsp_data_nx  = hold_nx;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         op            <= OP_LOADI;
         dst           <= '0;
         src           <= '0;
         hold          <= '0;
         bus.reg_index <= '0;
         bus.reg_rEn   <= 1'b0;
         bus.reg_wEn   <= 1'b0;
         bus.bus_load  <= 1'b0;
         bus.bus_val   <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.done      <= 1'b0;
      end else begin
         state         <= state_nx;
         op            <= op_nx;
         dst           <= dst_nx;
         src           <= src_nx;
         hold          <= hold_nx;
         bus.reg_index <= index_nx;
         bus.reg_rEn   <= ren_nx;
         bus.reg_wEn   <= wen_nx;
         bus.bus_load  <= load_nx;
         bus.bus_val   <= val_nx;
         bus.rsp_valid <= rsp_valid_nx;
         bus.rsp_data  <= rsp_data_nx;
         bus.done      <= done_nx;
      end
   end
endmodule
